// File: rtl/nios_qsys_led_pio_ex.sv
// nios_qsys_led_pio_ex: Avalon-MM LED output PIO.
// Provides a DATA_WIDTH output register with atomic set/clear and a hardware
// blink engine that toggles a masked subset of the outputs every
// BLINK_PERIOD+1 clocks.
// Optional PWM dimming is compiled in only when LED_PIO_PWM_EN is defined.
// It adds an 8-bit duty register at offset 6 and a free-running 8-bit PWM counter.
//
// Register map (word offsets):
//   0 DATA  1 BLINK_MASK  2 BLINK_PERIOD  3 STATUS {active, phase}
//   4 OUTSET (wo)  5 OUTCLEAR (wo)  6 PWM_DUTY  7 reserved
module nios_qsys_led_pio_ex #(
    parameter int unsigned           DATA_WIDTH   = 8,
    parameter int unsigned           PERIOD_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    typedef enum logic [2:0] {
        ADDR_DATA     = 3'd0,
        ADDR_MASK     = 3'd1,
        ADDR_PERIOD   = 3'd2,
        ADDR_STATUS   = 3'd3,
        ADDR_OUTSET   = 3'd4,
        ADDR_OUTCLEAR = 3'd5,
        ADDR_PWM_DUTY = 3'd6,
        ADDR_RSVD     = 3'd7
    } reg_addr_e;

    logic                    wr;
    logic                    period_wr;
    logic [DATA_WIDTH-1:0]   wd_data;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] blink_cnt_q;
    logic                    phase_q;
    logic                    pwm_on;

    assign wr        = chipselect & ~write_n;
    assign period_wr = wr && (address == ADDR_PERIOD);
    assign wd_data   = writedata[DATA_WIDTH-1:0];

    // Upper writedata bits are architecturally ignored; fold them here so the
    // port is fully consumed.
    logic unused_wd;
    assign unused_wd = ^writedata;

    // DATA register: plain write, atomic set and atomic clear.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else if (wr) begin
            case (address)
                ADDR_DATA:     data_q <= wd_data;
                ADDR_OUTSET:   data_q <= data_q | wd_data;
                ADDR_OUTCLEAR: data_q <= data_q & ~wd_data;
                default:       ;
            endcase
        end
    end

    // Blink mask and half-period configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= '0;
        end else if (wr) begin
            case (address)
                ADDR_MASK:   mask_q   <= wd_data;
                ADDR_PERIOD: period_q <= writedata[PERIOD_WIDTH-1:0];
                default:     ;
            endcase
        end
    end

    // Blink engine.
    // Any BLINK_PERIOD write restarts the engine from phase 0, which beats a
    // toggle landing on the same edge.
    // Period 0 parks the engine.
    always_ff @(posedge clk) begin
        if (reset || period_wr) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (period_q == '0) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else if (blink_cnt_q == period_q) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + PERIOD_WIDTH'(1);
        end
    end

`ifdef LED_PIO_PWM_EN
    logic [7:0] pwm_duty_q;
    logic [7:0] pwm_cnt_q;

    // PWM duty register and free-running 8-bit PWM counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_duty_q <= 8'hFF;
            pwm_cnt_q  <= 8'd0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (wr && (address == ADDR_PWM_DUTY)) begin
                pwm_duty_q <= writedata[7:0];
            end
        end
    end

    // Duty 255 is forced fully on.
    // Otherwise the gate opens for the first pwm_duty_q counts of every
    // 256-count PWM frame.
    assign pwm_on = (pwm_duty_q == 8'hFF) || (pwm_cnt_q < pwm_duty_q);
`else
    assign pwm_on = 1'b1;
`endif

    assign out_port = (data_q ^ (mask_q & {DATA_WIDTH{phase_q}})) & {DATA_WIDTH{pwm_on}};

    // Zero-latency read mux.
    // Write-only, reserved and compiled-out offsets return 0.
    // NOTE: readdata gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_MASK:     readdata = 32'(mask_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_STATUS:   readdata = {30'd0, (period_q != '0), phase_q};
`ifdef LED_PIO_PWM_EN
            ADDR_PWM_DUTY: readdata = 32'(pwm_duty_q);
`endif
            default:       readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_nios_qsys_led_pio_ex.sv
// Self-checking bench for nios_qsys_led_pio_ex (DATA_WIDTH=8, RESET_VALUE=8'hA5).
// Expectations come from directed constants and a behavioural model.
// The model derives the blink phase from the number of edges elapsed since the
// last restart and the PWM count from the edges elapsed since reset.
// It follows LED_PIO_PWM_EN in the same way as the design.
module tb_nios_qsys_led_pio_ex;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int total = 0;
    int bad   = 0;
    int edge_no = 0;

    // Reference model state.
    logic [7:0] m_data;
    logic [7:0] m_mask;
    logic [7:0] m_duty;
    int         m_period;
    int         m_start;
    int         m_rst_edge;

    always #5 clk = ~clk;

    nios_qsys_led_pio_ex #(
        .DATA_WIDTH  (8),
        .PERIOD_WIDTH(24),
        .RESET_VALUE (RV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    function automatic logic m_phase();
        int q;
        if (m_period == 0) return 1'b0;
        q = (edge_no - m_start) / (m_period + 1);
        return (q % 2) != 0;
    endfunction

    function automatic logic m_gate();
`ifdef LED_PIO_PWM_EN
        int c;
        c = (edge_no - m_rst_edge) % 256;
        return (m_duty == 8'hFF) || (c < int'(m_duty));
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] m_out();
        return (m_data ^ (m_mask & {8{m_phase()}})) & {8{m_gate()}};
    endfunction

    function automatic logic [31:0] m_read(input int a);
        case (a)
            0: return {24'd0, m_data};
            1: return {24'd0, m_mask};
            2: return 32'(m_period);
            3: return {30'd0, m_period != 0, m_phase()};
`ifdef LED_PIO_PWM_EN
            6: return {24'd0, m_duty};
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) begin
            step();
            m_data     = RV;
            m_mask     = 8'h00;
            m_duty     = 8'hFF;
            m_period   = 0;
            m_start    = edge_no;
            m_rst_edge = edge_no;
        end
        reset = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        case (a)
            3'd0: m_data = d[7:0];
            3'd1: m_mask = d[7:0];
            3'd2: begin m_period = int'(d[23:0]); m_start = edge_no; end
            3'd4: m_data = m_data | d[7:0];
            3'd5: m_data = m_data & ~d[7:0];
`ifdef LED_PIO_PWM_EN
            3'd6: m_duty = d[7:0];
`endif
            default: ;
        endcase
    endtask

    task automatic rd_check(input logic [2:0] a, input logic [31:0] exp, input string tag);
        address = a;
        #1;
        check(tag, readdata, exp);
    endtask

    task automatic check_model();
        int a;
        check("out_model", {24'd0, out_port}, {24'd0, m_out()});
        a = int'($urandom_range(0, 7));
        address = 3'(a);
        #1;
        check($sformatf("read%0d_model", a), readdata, m_read(a));
    endtask

    initial begin
        logic [7:0] exp8;
        int         cnt;
        logic [31:0] r;
        int          op;

        reset = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;

        // Reset held two cycles.
        do_reset(2);
        check("rst_out", {24'd0, out_port}, 32'h0000_00A5);
        rd_check(3'd1, 32'd0, "rst_mask");
        rd_check(3'd2, 32'd0, "rst_period");
        rd_check(3'd3, 32'd0, "rst_status");

        // DATA write, OUTSET, OUTCLEAR.
        wr(3'd0, 32'h0000_000F);
        check("data_0f", {24'd0, out_port}, 32'h0F);
        wr(3'd4, 32'h0000_00F0);
        check("outset", {24'd0, out_port}, 32'hFF);
        wr(3'd5, 32'h0000_0081);
        check("outclear", {24'd0, out_port}, 32'h7E);
        rd_check(3'd0, 32'h0000_007E, "rd_data");
        rd_check(3'd4, 32'd0, "rd_outset");
        rd_check(3'd5, 32'd0, "rd_outclear");
        wr(3'd4, 32'd0);
        check("outset0", {24'd0, out_port}, 32'h7E);

        // Blink mask 03, period 3: toggles every 4 cycles.
        wr(3'd0, 32'd0);
        wr(3'd1, 32'h03);
        wr(3'd2, 32'd3);
        check("blink_start", {24'd0, out_port}, 32'h00);
        for (int k = 1; k <= 13; k++) begin
            step();
            exp8 = (((k / 4) % 2) != 0) ? 8'h03 : 8'h00;
            check($sformatf("blink_out_k%0d", k), {24'd0, out_port}, {24'd0, exp8});
            rd_check(3'd3, {30'd0, 1'b1, exp8[0]}, $sformatf("blink_status_k%0d", k));
        end

        // Rewrite period while phase is 1: restart from phase 0.
        wr(3'd2, 32'd3);
        check("restart_out", {24'd0, out_port}, 32'h00);
        rd_check(3'd3, 32'h2, "restart_status");
        for (int k = 1; k <= 7; k++) begin
            step();
            exp8 = (k >= 4) ? 8'h03 : 8'h00;
            check($sformatf("restart_k%0d", k), {24'd0, out_port}, {24'd0, exp8});
        end

        // Period write landing on a toggle edge wins.
        wr(3'd2, 32'd3);
        check("toggle_edge_wr", {24'd0, out_port}, 32'h00);
        repeat (3) step();
        check("toggle_edge_n3", {24'd0, out_port}, 32'h00);
        step();
        check("toggle_edge_n4", {24'd0, out_port}, 32'h03);

        // Period 0 stops the engine at phase 0.
        wr(3'd2, 32'd0);
        check("stop_out", {24'd0, out_port}, 32'h00);
        repeat (10) step();
        check("stop_out_late", {24'd0, out_port}, 32'h00);
        rd_check(3'd3, 32'd0, "stop_status");

        // Reset mid-blink (phase 1, counter 2).
        wr(3'd2, 32'd3);
        repeat (6) step();
        check("preflush_out", {24'd0, out_port}, 32'h03);
        do_reset(1);
        check("midrst_out", {24'd0, out_port}, 32'hA5);
        rd_check(3'd3, 32'd0, "midrst_status");
        repeat (10) step();
        check("midrst_late", {24'd0, out_port}, 32'hA5);

        // PWM gate.
        wr(3'd0, 32'hFF);
`ifdef LED_PIO_PWM_EN
        wr(3'd6, 32'd64);
        rd_check(3'd6, 32'd64, "duty_rd");
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port == 8'hFF) cnt++;
        end
        check("pwm64_count", 32'(cnt), 32'd64);
        wr(3'd6, 32'd0);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port != 8'h00) cnt++;
        end
        check("pwm0_nonzero", 32'(cnt), 32'd0);
        wr(3'd6, 32'd255);
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port == 8'hFF) cnt++;
        end
        check("pwm255_count", 32'(cnt), 32'd256);
`else
        wr(3'd6, 32'd64);
        rd_check(3'd6, 32'd0, "off6_rd");
        cnt = 0;
        for (int k = 0; k < 256; k++) begin
            step();
            if (out_port == 8'hFF) cnt++;
        end
        check("nopwm_count", 32'(cnt), 32'd256);
`endif

        // Randomized operations checked against the model.
        for (int i = 0; i < 300; i++) begin
            r  = $urandom();
            op = int'($urandom_range(0, 10));
            if (op <= 7) begin
                if (op == 2) begin
                    r = {r[31:24], 24'($urandom_range(0, 9))};
                end
                wr(3'(op), r);
            end else if (op == 10 && r[3:0] == 4'd0) begin
                do_reset(1);
            end else begin
                step();
            end
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nios_qsys_led_pio_ex.md
Name: nios_qsys_led_pio_ex

Overview:
- Parametrised successor to the 8-bit LED output PIO: Avalon-MM slave with a DATA_WIDTH output register, atomic set/clear, and a hardware blink engine.
- Blink engine toggles a masked subset of outputs at a programmable period, so the Nios core no longer bit-bangs status LEDs.
- Sits on the system interconnect; out_port drives board LEDs.

Parameters:
- DATA_WIDTH, 8, output/register width (1..32).
- PERIOD_WIDTH, 24, width of the blink half-period register and counter (1..32).
- RESET_VALUE, 0, DATA register value after reset (DATA_WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word offset.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above the target register width are ignored.
- readdata  out  32  read data; zero-extended.
- out_port  out  DATA_WIDTH  LED drive.

Behaviour:
- Register map (wr = chipselect & ~write_n):
  - 0 DATA rw.
  - 1 BLINK_MASK rw.
  - 2 BLINK_PERIOD rw.
  - 3 STATUS ro: bit0 = blink phase, bit1 = blink active (BLINK_PERIOD != 0).
  - 4 OUTSET wo: DATA |= wd.
  - 5 OUTCLEAR wo: DATA &= ~wd.
  - 6 PWM_DUTY (see Optional Feature).
  - 7 reserved.
- readdata: combinational, zero read latency. Write-only, reserved and disabled offsets read 0. Reads have no side effects.
- Reset (sync, at clk edge with reset=1), all registers at once:
  - DATA = RESET_VALUE; BLINK_MASK = 0; BLINK_PERIOD = 0.
  - blink counter = 0; phase = 0.
  - out_port = RESET_VALUE (with PWM gate open) the cycle after the edge.
  - Reset mid-blink aborts the engine immediately; no partial period is carried over.
- Register writes take effect at the clk edge; out_port reflects the new value in the following cycle, with no extra pipeline stage.
- Blink engine:
  - BLINK_PERIOD == 0: engine idle; counter and phase held at 0.
  - BLINK_PERIOD = P > 0: counter increments every clk. When counter == P, counter <= 0 and phase toggles. Phase therefore toggles every P+1 cycles.
  - A write to BLINK_PERIOD (any value) clears counter and phase on the same edge.
  - Writes to DATA, BLINK_MASK, OUTSET or OUTCLEAR do not disturb counter or phase.
  - Counter wraps only through the == P compare, never by overflow, because P fits in PERIOD_WIDTH.
- Output function: out_port = (DATA ^ (BLINK_MASK & {DATA_WIDTH{phase}})) & gate. gate is all-ones when the optional feature is absent.
- Simultaneous events:
  - Only one register is written per cycle.
  - A phase toggle and a DATA write on the same edge both apply.
  - A BLINK_PERIOD write on a toggle edge wins: phase = 0.
  - reset has priority over everything.
- OUTSET/OUTCLEAR with wd = 0 leave DATA unchanged.

Optional Feature:
- Macro: LED_PIO_PWM_EN.
- Defined:
  - 8-bit PWM_DUTY register at offset 6 (rw, reset 8'hFF) and a free-running 8-bit pwm counter (reset 0, wraps 255 -> 0).
  - gate = (PWM_DUTY == 8'hFF) | (pwm_cnt < PWM_DUTY), replicated across all bits.
  - Duty 0 = always off; duty 255 = always on.
  - PWM is independent of the blink engine.
- Not defined: no PWM_DUTY register or counter; offset 6 reads 0 and ignores writes; gate = all-ones.

Test Plan:
- Reset with RESET_VALUE=8'hA5: assert reset 2 cycles -> out_port=8'hA5; reads of offsets 1, 2, 3 return 0.
- Write DATA=8'h0F, then OUTSET 8'hF0, then OUTCLEAR 8'h81 -> out_port 8'h0F, 8'hFF, 8'h7E on successive cycles; read offset 0 = 32'h0000_007E; offsets 4 and 5 read 0.
- DATA=8'h00, BLINK_MASK=8'h03, BLINK_PERIOD=3 -> out_port bits[1:0] toggle every 4 cycles (00,11,00...); STATUS bit0 tracks phase; other bits stay 0.
- Mid-blink with phase=1: write BLINK_PERIOD=3 again -> next cycle phase=0, counter=0, out_port[1:0]=00, first toggle 4 cycles later. Write BLINK_PERIOD=0 -> blinking stops with phase=0.
- Reset asserted mid-blink (phase=1, counter=2) -> one cycle later out_port=RESET_VALUE, STATUS=0; no toggle until BLINK_PERIOD is rewritten.
- With LED_PIO_PWM_EN defined, DATA=8'hFF, PWM_DUTY=64 -> over 256 cycles out_port=8'hFF for exactly 64 cycles. Duty 0 -> always 0; duty 255 -> always 8'hFF. Without the macro, offset 6 write 64 then read -> 0 and out_port stays 8'hFF.
